blink_pattern_seq: RTL and testbench
====================================

Name: blink_pattern_seq

Overview:
- Downstream consumer of the blinker's one-cycle wrap strobe (flg).
- Replays a software-loaded LED bit pattern, one bit per strobe, with a programmable repeat count.
- Drives the board LED in place of the raw mode toggle.
- Patterns are loaded through a valid/ready handshake; a done pulse signals completion.

Parameters:
- PBITS, 16, pattern length capacity in bits (≥2).
- RBITS, 4, width of the repeat-count field.
- LBITS, $clog2(PBITS), width of the length field. Derived; not overridable.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle step strobe (blinker flg); ignored outside SYNC/RUN
- pat_valid  in  1  pattern offer
- pat_ready  out  1  high only in IDLE with abort low
- pat_data  in  PBITS  pattern bits; bit 0 is played first
- pat_len  in  LBITS  number of bits minus 1 (0 → 1 bit … PBITS-1 → PBITS bits)
- pat_rep  in  RBITS  extra repetitions (0 → play once)
- abort  in  1  synchronous cancel
- led  out  1  registered pattern output
- busy  out  1  high in SYNC or RUN
- done  out  1  one-cycle pulse when the final bit period ends

Behaviour:
- Reset (async, rst_n=0): state=IDLE; led=0, busy=0, done=0; all internal registers cleared. pat_ready is combinational and goes to 1 on reset release.
- Reset mid-pattern: discards the pattern immediately; no done pulse.
- Accept: pat_valid && pat_ready at an edge latches data, len and rep; rep_cnt=pat_rep; idx=0; state→SYNC. pat_data is don't-care when not accepted.
- SYNC: led held 0. The first tick moves to RUN and sets led=pat_data[0] at that same edge, so led reflects the bit the cycle after the tick.
- RUN, per tick:
  - If idx<len: idx++, and led=pat[idx+1] at that edge.
  - If idx==len and rep_cnt≠0: rep_cnt--, idx=0, led=pat[0].
  - If idx==len and rep_cnt==0: state→IDLE, led=0, done=1 for one cycle, all at that edge.
- Between ticks: led, idx and rep_cnt are held.
- Each bit occupies exactly one tick interval.
- abort=1 at an edge in SYNC or RUN: state→IDLE, led=0, no done.
- abort has priority over tick and over accept. In IDLE with abort high, pat_ready=0.
- tick in IDLE: no effect.
- pat_valid while busy: not accepted (pat_ready=0); the offer must be held by the source.
- Counters never wrap: idx ≤ len ≤ PBITS-1; rep_cnt only decrements from a nonzero value.
- State encoding is 2-bit: IDLE=0, SYNC=1, RUN=2. The value 3 is illegal and recovers to IDLE with led=0.

Optional Feature:
- Macro: BLINK_PATTERN_SEQ_STATS_EN.
- Defined: adds output plays, width 8, counting completed patterns (each done pulse). It saturates at 255, is cleared only by rst_n, and aborts do not count.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package blink_pkg holds:
  - the state enum type seq_state_t (IDLE, SYNC, RUN);
  - localparam defaults PBITS_DEF=16 and RBITS_DEF=4;
  - function len_bits(PBITS).
- One natural sub-module, blink_pattern_shreg: holds pattern storage and bit select. Interface: load, advance, rewind inputs; bit output.
- The FSM, repeat counter and handshake remain in the top-level block.

Test Plan:
- Reset and idle: assert rst_n=0 mid-cycle → led=0, busy=0, done=0 asynchronously. After release, pat_ready=1. Ticks in IDLE leave led=0.
- Single play:
  - Stimulus: load pat_data=16'h0005, pat_len=3, pat_rep=0, then 5 ticks spaced 4 cycles apart.
  - led after ticks 1–4 = 1,0,1,0.
  - Tick 5 gives led=0 and a done pulse of exactly 1 cycle; busy falls and pat_ready=1 on the next cycle.
- Repeat:
  - Stimulus: pat_data=16'h0001, pat_len=1, pat_rep=2.
  - led sequence = 1,0,1,0,1,0; done on tick 7 only.
- Abort priority:
  - In RUN, assert abort and tick in the same cycle → IDLE, led=0, no done.
  - In IDLE, abort=1 with pat_valid=1 → pat_ready=0 and no load.
- Boundaries:
  - pat_len=15 with pat_data=16'h8000 → led high only after tick 16.
  - pat_len=0 with pat_data bit0=1 → one high period, done on tick 2.
  - Load offered while busy is held and accepted the cycle after done.
- With BLINK_PATTERN_SEQ_STATS_EN: 3 completed plays plus 1 abort → plays=3. Forcing 300 completions → plays=255.

Source files
------------

// File: rtl/blink_pattern_seq_pkg.sv
// Shared types and sizing helpers for the blink pattern sequencer.
// Holds the FSM state encoding and the default pattern/repeat widths.
package blink_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } seq_state_t;

  localparam int PBITS_DEF = 16;
  localparam int RBITS_DEF = 4;

  // Width of the pattern length/index fields for a given capacity.
  function automatic int len_bits(input int pbits);
    return (pbits <= 2) ? 1 : $clog2(pbits);
  endfunction

endpackage

// File: rtl/blink_pattern_seq_if.sv
// Pattern-load handshake bundle: valid/ready plus pattern data, length and repeat.
// The source drives the master modport; the sequencer receives it on the slave modport.
interface blink_pattern_seq_if #(
  parameter int PBITS = blink_pkg::PBITS_DEF,
  parameter int RBITS = blink_pkg::RBITS_DEF
);
  import blink_pkg::*;

  localparam int LBITS = len_bits(PBITS);

  logic             pat_valid;
  logic             pat_ready;
  logic [PBITS-1:0] pat_data;
  logic [LBITS-1:0] pat_len;
  logic [RBITS-1:0] pat_rep;

  modport master (
    output pat_valid,
    output pat_data,
    output pat_len,
    output pat_rep,
    input  pat_ready
  );

  modport slave (
    input  pat_valid,
    input  pat_data,
    input  pat_len,
    input  pat_rep,
    output pat_ready
  );

endinterface

// File: rtl/blink_pattern_seq_shreg.sv
// Pattern storage and bit selector for the blink sequencer.
// o_bit is the bit the LED should show after the step requested this cycle.
module blink_pattern_shreg #(
  parameter int PBITS = 16,
  parameter int LBITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [PBITS-1:0] i_data,
  input  logic             i_advance,
  input  logic             i_rewind,
  output logic             o_bit,
  output logic [LBITS-1:0] o_idx
);

  logic [PBITS-1:0] r_pat;
  logic [LBITS-1:0] r_idx;
  logic [LBITS-1:0] w_idx_inc;

  assign w_idx_inc = r_idx + LBITS'(1);
  assign o_idx     = r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat <= '0;
      r_idx <= '0;
    end else if (i_load) begin
      r_pat <= i_data;
      r_idx <= '0;
    end else if (i_rewind) begin
      r_idx <= '0;
    end else if (i_advance) begin
      r_idx <= w_idx_inc;
    end
  end

  // Look ahead so the registered LED lands on the new bit at the same edge.
  always_comb begin
    o_bit = r_pat[r_idx];
    if (i_rewind) begin
      o_bit = r_pat[0];
    end else if (i_advance) begin
      o_bit = r_pat[w_idx_inc];
    end
  end

endmodule

// File: rtl/blink_pattern_seq.sv
// Replays a loaded LED bit pattern, one bit per blinker strobe, with repeats.
// Optional macro BLINK_PATTERN_SEQ_STATS_EN adds the saturating 'plays' counter.
module blink_pattern_seq
  import blink_pkg::*;
#(
  parameter int PBITS = PBITS_DEF,
  parameter int RBITS = RBITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                abort,
  blink_pattern_seq_if.slave  pat,
  output logic                led,
  output logic                busy,
  output logic                done
`ifdef BLINK_PATTERN_SEQ_STATS_EN
  ,
  output logic [7:0]          plays
`endif
);

  localparam int LBITS = len_bits(PBITS);

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  logic             r_led;
  logic             w_led_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic [LBITS-1:0] r_len;
  logic [LBITS-1:0] w_len_nxt;
  logic [RBITS-1:0] r_rep;
  logic [RBITS-1:0] w_rep_nxt;

  logic             w_accept;
  logic             w_step;
  logic             w_at_end;
  logic             w_adv;
  logic             w_rew;
  logic             w_bit;
  logic [LBITS-1:0] w_idx;

  assign pat.pat_ready = (r_state == IDLE) && !abort;
  assign w_accept      = pat.pat_valid && pat.pat_ready;
  assign w_step        = tick && !abort;
  assign w_at_end      = (w_idx == r_len);
  assign w_adv         = (r_state == RUN) && w_step && !w_at_end;
  assign w_rew         = (r_state == RUN) && w_step && w_at_end && (r_rep != '0);

  assign led  = r_led;
  assign done = r_done;
  assign busy = (r_state == SYNC) || (r_state == RUN);

  blink_pattern_shreg #(
    .PBITS (PBITS),
    .LBITS (LBITS)
  ) u_shreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_accept),
    .i_data    (pat.pat_data),
    .i_advance (w_adv),
    .i_rewind  (w_rew),
    .o_bit     (w_bit),
    .o_idx     (w_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_led   <= 1'b0;
      r_done  <= 1'b0;
      r_len   <= '0;
      r_rep   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_led   <= w_led_nxt;
      r_done  <= w_done_nxt;
      r_len   <= w_len_nxt;
      r_rep   <= w_rep_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_led_nxt   = r_led;
    w_done_nxt  = 1'b0;
    w_len_nxt   = r_len;
    w_rep_nxt   = r_rep;
    case (r_state)
      IDLE: begin
        w_led_nxt = 1'b0;
        if (w_accept) begin
          w_len_nxt   = pat.pat_len;
          w_rep_nxt   = pat.pat_rep;
          w_state_nxt = SYNC;
        end
      end
      SYNC: begin
        if (abort) begin
          w_state_nxt = IDLE;
          w_led_nxt   = 1'b0;
        end else if (tick) begin
          w_state_nxt = RUN;
          w_led_nxt   = w_bit;
        end
      end
      RUN: begin
        if (abort) begin
          w_state_nxt = IDLE;
          w_led_nxt   = 1'b0;
        end else if (tick) begin
          if (!w_at_end) begin
            w_led_nxt = w_bit;
          end else if (r_rep != '0) begin
            w_rep_nxt = r_rep - RBITS'(1);
            w_led_nxt = w_bit;
          end else begin
            w_state_nxt = IDLE;
            w_led_nxt   = 1'b0;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_led_nxt   = 1'b0;
      end
    endcase
  end

`ifdef BLINK_PATTERN_SEQ_STATS_EN
  logic [7:0] r_plays;

  assign plays = r_plays;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_plays <= 8'd0;
    end else if (w_done_nxt && (r_plays != 8'hFF)) begin
      r_plays <= r_plays + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_blink_pattern_seq.sv
// Directed bench for blink_pattern_seq; define BLINK_PATTERN_SEQ_STATS_EN to cover 'plays'.
module tb_blink_pattern_seq;
  import blink_pkg::*;

  logic clk;
  logic rst_n;
  logic tick;
  logic abort;
  logic led;
  logic busy;
  logic done;
`ifdef BLINK_PATTERN_SEQ_STATS_EN
  logic [7:0] plays;
`endif

  int n_checks;
  int n_fail;

  blink_pattern_seq_if #(.PBITS(16), .RBITS(4)) pif ();

  blink_pattern_seq #(.PBITS(16), .RBITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick),
    .abort (abort),
    .pat   (pif.slave),
    .led   (led),
    .busy  (busy),
    .done  (done)
`ifdef BLINK_PATTERN_SEQ_STATS_EN
    ,
    .plays (plays)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] l, input logic [3:0] r);
    pif.pat_valid = 1'b1;
    pif.pat_data  = d;
    pif.pat_len   = l;
    pif.pat_rep   = r;
    cyc(1);
    pif.pat_valid = 1'b0;
    pif.pat_data  = 16'h0;
  endtask

  task automatic tick1();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
  endtask

  logic [4:0]  e_single;
  logic [6:0]  e_rep;

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    tick          = 1'b0;
    abort         = 1'b0;
    pif.pat_valid = 1'b0;
    pif.pat_data  = 16'h0;
    pif.pat_len   = 4'd0;
    pif.pat_rep   = 4'd0;
    e_single      = 5'b00101;
    e_rep         = 7'b0010101;

    // Reset and idle
    #12;
    chk1("rst_led", led, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    rst_n = 1'b1;
    #1;
    chk1("rst_ready", pif.pat_ready, 1'b1);
    cyc(1);
    tick1();
    tick1();
    chk1("idle_tick_led", led, 1'b0);
    chk1("idle_tick_busy", busy, 1'b0);

    // Single play
    load(16'h0005, 4'd3, 4'd0);
    chk1("single_busy", busy, 1'b1);
    chk1("single_sync_led", led, 1'b0);
    chk1("single_sync_ready", pif.pat_ready, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      tick1();
      chk1($sformatf("single_led_t%0d", i), led, e_single[i-1]);
      chk1($sformatf("single_done_t%0d", i), done, 1'(i == 5));
      if (i < 5) begin
        cyc(3);
        chk1($sformatf("single_hold_t%0d", i), led, e_single[i-1]);
      end
    end
    chk1("single_end_busy", busy, 1'b0);
    cyc(1);
    chk1("single_done_clear", done, 1'b0);
    chk1("single_end_ready", pif.pat_ready, 1'b1);

    // Repeat
    load(16'h0001, 4'd1, 4'd2);
    for (int i = 1; i <= 7; i++) begin
      tick1();
      chk1($sformatf("rep_led_t%0d", i), led, e_rep[i-1]);
      chk1($sformatf("rep_done_t%0d", i), done, 1'(i == 7));
      cyc(2);
    end

    // Abort has priority over tick
    load(16'hFFFF, 4'd15, 4'd0);
    tick1();
    chk1("abort_pre_led", led, 1'b1);
    abort = 1'b1;
    tick  = 1'b1;
    cyc(1);
    abort = 1'b0;
    tick  = 1'b0;
    chk1("abort_led", led, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_done", done, 1'b0);
    cyc(1);
    chk1("abort_done_late", done, 1'b0);

    // Abort in IDLE blocks a load
    abort         = 1'b1;
    pif.pat_valid = 1'b1;
    pif.pat_data  = 16'h0001;
    pif.pat_len   = 4'd0;
    pif.pat_rep   = 4'd0;
    #1;
    chk1("idle_abort_ready", pif.pat_ready, 1'b0);
    cyc(1);
    chk1("idle_abort_noload", busy, 1'b0);
    abort         = 1'b0;
    pif.pat_valid = 1'b0;
    #1;
    chk1("idle_ready_back", pif.pat_ready, 1'b1);

    // Full-length pattern, only last bit set
    load(16'h8000, 4'd15, 4'd0);
    for (int i = 1; i <= 17; i++) begin
      tick1();
      chk1($sformatf("len15_led_t%0d", i), led, 1'(i == 16));
      chk1($sformatf("len15_done_t%0d", i), done, 1'(i == 17));
    end

    // Single-bit pattern
    load(16'h0001, 4'd0, 4'd0);
    tick1();
    chk1("len0_led_t1", led, 1'b1);
    chk1("len0_done_t1", done, 1'b0);
    cyc(2);
    tick1();
    chk1("len0_led_t2", led, 1'b0);
    chk1("len0_done_t2", done, 1'b1);

    // Offer held while busy, accepted the cycle after done
    cyc(1);
    load(16'h0003, 4'd1, 4'd0);
    pif.pat_valid = 1'b1;
    pif.pat_data  = 16'h0002;
    pif.pat_len   = 4'd1;
    pif.pat_rep   = 4'd0;
    #1;
    chk1("held_ready_busy", pif.pat_ready, 1'b0);
    tick1();
    chk1("held_led_t1", led, 1'b1);
    tick1();
    chk1("held_led_t2", led, 1'b1);
    tick1();
    chk1("held_done", done, 1'b1);
    chk1("held_busy_low", busy, 1'b0);
    chk1("held_ready_up", pif.pat_ready, 1'b1);
    cyc(1);
    pif.pat_valid = 1'b0;
    chk1("held_accepted", busy, 1'b1);
    tick1();
    chk1("held2_led_t1", led, 1'b0);
    tick1();
    chk1("held2_led_t2", led, 1'b1);
    tick1();
    chk1("held2_done", done, 1'b1);

    // Reset mid-pattern discards immediately
    load(16'h0001, 4'd2, 4'd0);
    tick1();
    chk1("midrst_pre_led", led, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("midrst_led", led, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_done", done, 1'b0);
`ifdef BLINK_PATTERN_SEQ_STATS_EN
    chk8("midrst_plays", plays, 8'd0);
`endif
    #3;
    rst_n = 1'b1;
    cyc(1);
    tick1();
    chk1("midrst_after_done", done, 1'b0);
    chk1("midrst_after_led", led, 1'b0);

`ifdef BLINK_PATTERN_SEQ_STATS_EN
    // Completions count, aborts do not, counter saturates
    for (int i = 0; i < 3; i++) begin
      load(16'h0001, 4'd0, 4'd0);
      tick1();
      tick1();
    end
    load(16'h0001, 4'd3, 4'd0);
    tick1();
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    chk8("stats_three", plays, 8'd3);
    for (int i = 0; i < 300; i++) begin
      load(16'h0001, 4'd0, 4'd0);
      tick1();
      tick1();
    end
    chk8("stats_sat", plays, 8'd255);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
